// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, coordinate width and sprite-window type,
// used by the timing generator and the downstream sprite stage.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_HPIXELS = 800;
  localparam int VGA_VLINES  = 521;
  localparam int VGA_HSP     = 128;
  localparam int VGA_VSP     = 2;
  localparam int VGA_HBP     = 144;
  localparam int VGA_HFP     = 784;
  localparam int VGA_VBP     = 31;
  localparam int VGA_VFP     = 511;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t hbp;
    coord_t hfp;
    coord_t vbp;
    coord_t vfp;
  } win_t;

  // Half-open interval test lo <= v < hi, matching the sprite stage compares.
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: pix_en is a registered one-clk strobe, high in the
// cycle the divide counter sits at CLK_DIV-1 (constantly high for CLK_DIV=1).
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing plus a frame-synchronous sprite-window register set.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output and its counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int HPIXELS = VGA_HPIXELS,
  parameter int VLINES  = VGA_VLINES,
  parameter int HSP     = VGA_HSP,
  parameter int VSP     = VGA_VSP,
  parameter int HBP     = VGA_HBP,
  parameter int HFP     = VGA_HFP,
  parameter int VBP     = VGA_VBP,
  parameter int VFP     = VGA_VFP
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_en,
  output logic [COORD_W-1:0] hc,
  output logic [COORD_W-1:0] vc,
  output logic               hsync,
  output logic               vsync,
  output logic               vidon,
  output logic               frame_start,
  input  logic               win_wr,
  input  logic [COORD_W-1:0] win_hbp_i,
  input  logic [COORD_W-1:0] win_hfp_i,
  input  logic [COORD_W-1:0] win_vbp_i,
  input  logic [COORD_W-1:0] win_vfp_i,
  output logic [COORD_W-1:0] hbp,
  output logic [COORD_W-1:0] hfp,
  output logic [COORD_W-1:0] vbp,
  output logic [COORD_W-1:0] vfp,
  output logic               win_busy
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam coord_t H_LAST = coord_t'(HPIXELS - 1);
  localparam coord_t V_LAST = coord_t'(VLINES - 1);
  localparam coord_t HSP_C  = coord_t'(HSP);
  localparam coord_t VSP_C  = coord_t'(VSP);
  localparam coord_t HBP_C  = coord_t'(HBP);
  localparam coord_t HFP_C  = coord_t'(HFP);
  localparam coord_t VBP_C  = coord_t'(VBP);
  localparam coord_t VFP_C  = coord_t'(VFP);
  localparam win_t   WIN_RST = {HBP_C, HFP_C, VBP_C, VFP_C};

  logic   pix_en_w;
  coord_t hc_q, hc_d, vc_q, vc_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d, vidon_q, vidon_d;
  logic   frame_start_q, frame_start_d;
  win_t   win_in, win_act_q, win_act_d, win_pend_q, win_pend_d;
  logic   win_busy_q, win_busy_d;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en_w)
  );

  assign win_in = {win_hbp_i, win_hfp_i, win_vbp_i, win_vfp_i};

  // Syncs and vidon decode from the next coordinates so they register alongside hc/vc.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en_w) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
    frame_start_d = pix_en_w && (hc_q == H_LAST) && (vc_q == V_LAST);
    hsync_d       = !(hc_d < HSP_C);
    vsync_d       = !(vc_d < VSP_C);
    vidon_d       = in_span(hc_d, HBP_C, HFP_C) && in_span(vc_d, VBP_C, VFP_C);
  end

  // A write landing on the frame_start cycle goes straight to the active set.
  always_comb begin
    win_act_d  = win_act_q;
    win_pend_d = win_pend_q;
    win_busy_d = win_busy_q;
    if (frame_start_q) begin
      if (win_wr) begin
        win_act_d = win_in;
      end else if (win_busy_q) begin
        win_act_d = win_pend_q;
      end
      win_busy_d = 1'b0;
    end else if (win_wr) begin
      win_pend_d = win_in;
      win_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vidon_q       <= 1'b0;
      frame_start_q <= 1'b0;
      win_act_q     <= WIN_RST;
      win_pend_q    <= WIN_RST;
      win_busy_q    <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vidon_q       <= vidon_d;
      frame_start_q <= frame_start_d;
      win_act_q     <= win_act_d;
      win_pend_q    <= win_pend_d;
      win_busy_q    <= win_busy_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(frame_start_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_en      = pix_en_w;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vidon       = vidon_q;
  assign frame_start = frame_start_q;
  assign hbp         = win_act_q.hbp;
  assign hfp         = win_act_q.hfp;
  assign vbp         = win_act_q.vbp;
  assign vfp         = win_act_q.vfp;
  assign win_busy    = win_busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: directed scenarios plus random
// window writes, all checked against a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int D      = 2;
  localparam int H      = 40;
  localparam int V      = 20;
  localparam int HSP_T  = 6;
  localparam int VSP_T  = 2;
  localparam int HBP_T  = 8;
  localparam int HFP_T  = 36;
  localparam int VBP_T  = 3;
  localparam int VFP_T  = 18;
  localparam int TOTAL  = H * V;
  localparam int BUDGET = 2 * TOTAL * D + 50;
  localparam logic [39:0] WIN_DEF = {10'(HBP_T), 10'(HFP_T), 10'(VBP_T), 10'(VFP_T)};

  logic       clk;
  logic       rst_n;
  logic       pix_en, hsync, vsync, vidon, frame_start, win_busy;
  logic [9:0] hc, vc, hbp, hfp, vbp, vfp;
  logic       win_wr;
  logic [9:0] win_hbp_i, win_hfp_i, win_vbp_i, win_vfp_i;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_timing_gen #(
    .CLK_DIV(D), .HPIXELS(H), .VLINES(V), .HSP(HSP_T), .VSP(VSP_T),
    .HBP(HBP_T), .HFP(HFP_T), .VBP(VBP_T), .VFP(VFP_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hc          (hc),
    .vc          (vc),
    .hsync       (hsync),
    .vsync       (vsync),
    .vidon       (vidon),
    .frame_start (frame_start),
    .win_wr      (win_wr),
    .win_hbp_i   (win_hbp_i),
    .win_hfp_i   (win_hfp_i),
    .win_vbp_i   (win_vbp_i),
    .win_vfp_i   (win_vfp_i),
    .hbp         (hbp),
    .hfp         (hfp),
    .vbp         (vbp),
    .vfp         (vfp),
    .win_busy    (win_busy)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_on = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: position is a linear pixel index advanced once per pixel strobe.
  int unsigned n_m, k_m, fcnt_m;
  bit          adv_m, busy_m;
  logic [39:0] act_m, pend_m;
  logic [39:0] win_in_tb;
  assign win_in_tb = {win_hbp_i, win_hfp_i, win_vbp_i, win_vfp_i};

  function automatic int unsigned idx_of(input int unsigned k);
    return (TOTAL - 1 + k) % TOTAL;
  endfunction

  function automatic bit pix_of(input int unsigned n);
    return (n > 0) && ((n % D) == D - 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      n_m = 0; k_m = 0; adv_m = 0; fcnt_m = 0;
      act_m = WIN_DEF; pend_m = WIN_DEF; busy_m = 0;
    end else begin
      if (adv_m && idx_of(k_m) == 0) begin
        if (win_wr) act_m = win_in_tb;
        else if (busy_m) act_m = pend_m;
        busy_m = 0;
      end else if (win_wr) begin
        pend_m = win_in_tb;
        busy_m = 1;
      end
      adv_m = pix_of(n_m);
      if (adv_m) k_m++;
      n_m++;
      if (adv_m && idx_of(k_m) == 0) fcnt_m = (fcnt_m + 1) % 65536;
    end
  end

  int unsigned e_idx, e_hc, e_vc, e_fcnt;
  bit          e_pix, e_fs, e_busy;
  logic [39:0] e_win;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        e_idx = TOTAL - 1; e_pix = 0; e_fs = 0; e_win = WIN_DEF; e_busy = 0; e_fcnt = 0;
      end else begin
        e_idx = idx_of(k_m); e_pix = pix_of(n_m); e_fs = adv_m && (e_idx == 0);
        e_win = act_m; e_busy = busy_m; e_fcnt = fcnt_m;
      end
      e_hc = e_idx % H;
      e_vc = e_idx / H;
      check_eq("hc", hc, e_hc);
      check_eq("vc", vc, e_vc);
      check_eq("hsync", hsync, e_hc >= HSP_T);
      check_eq("vsync", vsync, e_vc >= VSP_T);
      check_eq("vidon", vidon, (e_hc >= HBP_T) && (e_hc < HFP_T) && (e_vc >= VBP_T) && (e_vc < VFP_T));
      check_eq("pix_en", pix_en, e_pix);
      check_eq("frame_start", frame_start, e_fs);
      check_eq("window", {hbp, hfp, vbp, vfp}, e_win);
      check_eq("win_busy", win_busy, e_busy);
`ifdef VGA_FRAME_CNT_EN
      check_eq("frame_cnt", frame_cnt, e_fcnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string tag);
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (frame_start) break;
    end
    check_eq(tag, frame_start, 1);
  endtask

  task automatic wait_pos(input int h, input int v, input string tag);
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (hc == 10'(h) && vc == 10'(v)) break;
    end
    check_eq(tag, {hc, vc}, {10'(h), 10'(v)});
  endtask

  task automatic drive_win(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
    win_wr = 1'b1; win_hbp_i = a; win_hfp_i = b; win_vbp_i = c; win_vfp_i = d;
  endtask

  int cnt_pix, cnt_hs, cnt_vs, cnt_vid;

  initial begin
    rst_n = 1'b1;
    win_wr = 1'b0; win_hbp_i = '0; win_hfp_i = '0; win_vbp_i = '0; win_vfp_i = '0;
    #2 rst_n = 1'b0;
    mon_on = 1'b1;
    #1;
    check_eq("rst_hc", hc, H - 1);
    check_eq("rst_vc", vc, V - 1);
    check_eq("rst_window", {hbp, hfp, vbp, vfp}, WIN_DEF);
    repeat (3) tick();
    rst_n = 1'b1;

    // First strobe after reset wraps to (0,0) with both syncs active.
    wait_fs("first_fs");
    check_eq("first_hc", hc, 0);
    check_eq("first_vc", vc, 0);
    check_eq("first_hsync", hsync, 0);
    check_eq("first_vsync", vsync, 0);

    cnt_pix = 0; cnt_hs = 0; cnt_vs = 0; cnt_vid = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (frame_start) break;
      if (pix_en) begin
        cnt_pix++;
        if (!hsync && vc == 0) cnt_hs++;
        if (!vsync && hc == 0) cnt_vs++;
        if (vidon) cnt_vid++;
      end
    end
    check_eq("frame_len", cnt_pix, TOTAL);
    check_eq("hsync_width", cnt_hs, HSP_T);
    check_eq("vsync_lines", cnt_vs, VSP_T);
    check_eq("vidon_pixels", cnt_vid, (HFP_T - HBP_T) * (VFP_T - VBP_T));

    // Mid-frame write waits for the next frame start.
    wait_pos(10, 5, "pos_mid");
    drive_win(10'd200, 10'd300, 10'd4, 10'd9);
    tick();
    win_wr = 1'b0;
    check_eq("mid_busy", win_busy, 1);
    check_eq("mid_hbp_held", hbp, HBP_T);
    repeat (20) tick();
    check_eq("mid_hfp_held", hfp, HFP_T);
    wait_fs("fs_apply");
    tick();
    check_eq("apply_hbp", hbp, 200);
    check_eq("apply_hfp", hfp, 300);
    check_eq("apply_busy", win_busy, 0);

    // Write coincident with frame_start bypasses the pending set.
    wait_fs("fs_bypass");
    drive_win(10'd50, 10'd60, 10'd7, 10'd11);
    tick();
    win_wr = 1'b0;
    check_eq("bypass_busy", win_busy, 0);
    check_eq("bypass_hbp", hbp, 50);

    // Two writes in one frame: last one wins.
    wait_pos(5, 4, "pos_two");
    drive_win(10'd11, 10'd22, 10'd1, 10'd2);
    tick();
    drive_win(10'd33, 10'd44, 10'd5, 10'd6);
    tick();
    win_wr = 1'b0;
    wait_fs("fs_two");
    tick();
    check_eq("last_write_win", {hbp, hfp, vbp, vfp}, {10'd33, 10'd44, 10'd5, 10'd6});

    // Random window traffic, including writes on frame_start cycles.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3)
        drive_win(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
      else
        win_wr = 1'b0;
      tick();
    end
    win_wr = 1'b0;

    // Asynchronous reset mid-frame with an update pending.
    wait_pos(20, 10, "pos_reset");
    drive_win(10'd123, 10'd321, 10'd12, 10'd13);
    tick();
    win_wr = 1'b0;
    check_eq("pre_rst_busy", win_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_hc", hc, H - 1);
    check_eq("arst_vc", vc, V - 1);
    check_eq("arst_busy", win_busy, 0);
    check_eq("arst_window", {hbp, hfp, vbp, vfp}, WIN_DEF);
    check_eq("arst_syncs", {hsync, vsync, vidon, frame_start, pix_en}, 5'b11000);
`ifdef VGA_FRAME_CNT_EN
    check_eq("arst_frame_cnt", frame_cnt, 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) wait_fs("fs_after_rst");
    check_eq("post_rst_window", {hbp, hfp, vbp, vfp}, WIN_DEF);
`ifdef VGA_FRAME_CNT_EN
    check_eq("frame_cnt_3", frame_cnt, 3);
`endif
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
